// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'h0;
  localparam alu_op_t OP_SUB  = 4'h1;
  localparam alu_op_t OP_MOV  = 4'h2;
  localparam alu_op_t OP_AND  = 4'h3;
  localparam alu_op_t OP_ORR  = 4'h4;
  localparam alu_op_t OP_MLS  = 4'h5;
  localparam alu_op_t OP_EOR  = 4'h6;
  localparam alu_op_t OP_MVN  = 4'h7;
  localparam alu_op_t OP_MLA  = 4'h8;
  localparam alu_op_t OP_RSB  = 4'h9;
  localparam alu_op_t OP_ADC  = 4'hA;
  localparam alu_op_t OP_SBC  = 4'hB;
  localparam alu_op_t OP_MUL  = 4'hC;
  localparam alu_op_t OP_UDIV = 4'hD;
  localparam alu_op_t OP_SDIV = 4'hE;
  localparam alu_op_t OP_RSVD = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes that run on the iterative multiplier.
  function automatic logic is_mul_op(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_MLA) || (op == OP_MLS);
  endfunction

  // Opcodes that run on the iterative divider.
  function automatic logic is_div_op(input alu_op_t op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative core: MSB-first radix-2 shift-add multiply and restoring divide.
// A start loads the operands; WIDTH steps follow. done_o is high during the
// final step and res_o then shows that step's outcome (sign-fixed for SDIV).
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product or quotient under construction
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier or dividend, consumed MSB first
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   rem_shift_s, rem_diff_s;
  logic             q_bit_s;

  // Operand magnitudes, one iteration step and the next-state selection.
  always_comb begin
    mag_a_s     = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    mag_b_s     = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
    rem_shift_s = {rem_q, opb_q[WIDTH-1]};
    rem_diff_s  = rem_shift_s - {1'b0, opa_q};
    q_bit_s     = ~rem_diff_s[WIDTH];
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    rem_d       = rem_q;
    is_div_d    = is_div_q;
    neg_d       = neg_q;
    if (start_i) begin
      cnt_d    = CW'(WIDTH);
      acc_d    = {WIDTH{1'b0}};
      rem_d    = {WIDTH{1'b0}};
      opa_d    = is_div_i ? mag_b_s : a_i;
      opb_d    = is_div_i ? mag_a_s : b_i;
      is_div_d = is_div_i;
      neg_d    = is_div_i && signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - CW'(1);
      opb_d = {opb_q[WIDTH-2:0], 1'b0};
      if (is_div_q) begin
        acc_d = {acc_q[WIDTH-2:0], q_bit_s};
        rem_d = q_bit_s ? rem_diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
      end else begin
        acc_d = {acc_q[WIDTH-2:0], 1'b0} + (opb_q[WIDTH-1] ? opa_q : {WIDTH{1'b0}});
        rem_d = rem_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    done_o = (cnt_q == CW'(1));
    res_o  = neg_q ? (~acc_d + WIDTH'(1)) : acc_d;
  end

  // Iteration state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      opa_q    <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU top: handshake FSM, single-cycle datapath and NZCV logic.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t           state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] result_q, acc_c_q;
  logic [3:0]       flags_q;
  alu_op_t          op_q;

  logic             accept_s, start_s, div_zero_s, core_done_s;
  logic [WIDTH-1:0] core_res_s, md_res_s;
  logic [WIDTH-1:0] x_s, y_s, alu_res_s;
  logic [WIDTH:0]   sum_s;
  logic             ci_s, is_arith_s, ovf_s;
  logic [3:0]       alu_flags_s;

  // Pack {N,Z,C,V}; N and Z always follow the result.
  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == {WIDTH{1'b0}});
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign accept_s   = in_valid && in_ready_q;
  assign div_zero_s = (src_b == {WIDTH{1'b0}});
  assign start_s    = accept_s && (is_mul_op(op) || (is_div_op(op) && !div_zero_s));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_s),
    .is_div_i (is_div_op(op)),
    .signed_i (op == OP_SDIV),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (core_done_s),
    .res_o    (core_res_s)
  );

  // Single-cycle datapath: subtracts are x + ~y + cin so C is the ARM not-borrow.
  always_comb begin
    x_s        = src_a;
    y_s        = src_b;
    ci_s       = 1'b0;
    is_arith_s = 1'b0;
    case (op)
      OP_ADD:  begin is_arith_s = 1'b1; end
      OP_ADC:  begin is_arith_s = 1'b1; ci_s = carry_in; end
      OP_SUB:  begin is_arith_s = 1'b1; y_s = ~src_b; ci_s = 1'b1; end
      OP_SBC:  begin is_arith_s = 1'b1; y_s = ~src_b; ci_s = carry_in; end
      OP_RSB:  begin is_arith_s = 1'b1; x_s = src_b; y_s = ~src_a; ci_s = 1'b1; end
      default: begin is_arith_s = 1'b0; end
    endcase
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, ci_s};
    ovf_s = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum_s[WIDTH-1] != x_s[WIDTH-1]);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: alu_res_s = sum_s[WIDTH-1:0];
      OP_MOV:  alu_res_s = src_b;
      OP_MVN:  alu_res_s = ~src_b;
      OP_AND:  alu_res_s = src_a & src_b;
      OP_ORR:  alu_res_s = src_a | src_b;
      OP_EOR:  alu_res_s = src_a ^ src_b;
      default: alu_res_s = {WIDTH{1'b0}};  // reserved and divide-by-zero
    endcase
    alu_flags_s = make_flags(alu_res_s, is_arith_s & sum_s[WIDTH], is_arith_s & ovf_s);
  end

  // Final-step accumulate for MLA/MLS on the core's product.
  always_comb begin
    case (op_q)
      OP_MLA:  md_res_s = acc_c_q + core_res_s;
      OP_MLS:  md_res_s = acc_c_q - core_res_s;
      default: md_res_s = core_res_s;
    endcase
  end

  // Handshake FSM with registered ready/valid/result/flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      op_q        <= OP_ADD;
      acc_c_q     <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= !accept_s;
          if (accept_s) begin
            op_q    <= op;
            acc_c_q <= src_c;
            if (is_mul_op(op)) begin
              state_q <= MUL;
            end else if (is_div_op(op) && !div_zero_s) begin
              state_q <= DIV;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_s;
              flags_q     <= alu_flags_s;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        MUL, DIV: begin
          if (core_done_s) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_res_s;
            flags_q     <= make_flags(md_res_s, 1'b0, 1'b0);
          end else begin
            state_q <= state_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expectations, a monitor
// pops and compares each time out_valid rises.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, src_c;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, c;
    logic        cin;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    string       nm;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   issued = 0;
  int   aborted = 0;
  int   results_seen = 0;
  logic ov_prev = 1'b0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .src_c     (src_c),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  // Monitor: one comparison set per rising out_valid.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && ov_prev === 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%h required=none", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        results_seen++;
        chk({e.nm, "_result"}, result, e.res);
        chk({e.nm, "_flags"}, {28'd0, flags}, {28'd0, e.flg});
        chk({e.nm, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        chk({e.nm, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic ci, input logic [31:0] er,
                      input logic [3:0] ef, input int el, input string nm, output int acc);
    int w;
    exp_t e;
    w = 0;
    acc = -1;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=%b required=1", nm, in_ready);
    end else begin
      op       = o;
      src_a    = a;
      src_b    = b;
      src_c    = c;
      carry_in = ci;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 4'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      src_c    = $urandom;
      carry_in = 1'($urandom);
      e.res = er;
      e.flg = ef;
      e.lat = el;
      e.acc = cyc - 1;
      e.nm  = nm;
      sb_q.push_back(e);
      issued++;
      acc = cyc - 1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   a0, a1;
    int   w;
    logic seen;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'h0; src_a = 32'd0; src_b = 32'd0; src_c = 32'd0; carry_in = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    vecs.push_back('{4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 32'h80000000, 4'b1001, 1, "add_ovf"});
    vecs.push_back('{4'h1, 32'd5, 32'd5, 32'h0, 1'b0, 32'd0, 4'b0110, 1, "sub_zero"});
    vecs.push_back('{4'hB, 32'd5, 32'd3, 32'h0, 1'b0, 32'd1, 4'b0010, 1, "sbc"});
    vecs.push_back('{4'h8, 32'd3, 32'd4, 32'd10, 1'b0, 32'd22, 4'b0000, 33, "mla"});
    vecs.push_back('{4'hC, 32'h10000, 32'h10000, 32'h0, 1'b0, 32'd0, 4'b0100, 33, "mul_wrap"});
    vecs.push_back('{4'hE, 32'hFFFFFFF9, 32'd2, 32'h0, 1'b0, 32'hFFFFFFFD, 4'b1000, 33, "sdiv_neg"});
    vecs.push_back('{4'hD, 32'd7, 32'd0, 32'h0, 1'b0, 32'd0, 4'b0100, 1, "udiv_zero"});
    vecs.push_back('{4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h80000000, 4'b1000, 33, "sdiv_min"});
    vecs.push_back('{4'hA, 32'hFFFFFFFF, 32'd0, 32'h0, 1'b1, 32'd0, 4'b0110, 1, "adc_carry"});
    vecs.push_back('{4'h9, 32'd3, 32'd1, 32'h0, 1'b0, 32'hFFFFFFFE, 4'b1000, 1, "rsb_borrow"});
    vecs.push_back('{4'h5, 32'd2, 32'd3, 32'd5, 1'b0, 32'hFFFFFFFF, 4'b1000, 33, "mls"});
    vecs.push_back('{4'hD, 32'd100, 32'd7, 32'h0, 1'b0, 32'd14, 4'b0000, 33, "udiv"});
    vecs.push_back('{4'hE, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b0, 32'hFFFFFFFD, 4'b1000, 33, "sdiv_negb"});
    vecs.push_back('{4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0, 1'b0, 32'h0000F000, 4'b0000, 1, "and"});
    vecs.push_back('{4'h4, 32'h0000000F, 32'h000000F0, 32'h0, 1'b0, 32'h000000FF, 4'b0000, 1, "orr"});
    vecs.push_back('{4'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'd0, 4'b0100, 1, "eor"});
    vecs.push_back('{4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h1, 1'b1, 32'd0, 4'b0100, 1, "reserved"});
    vecs.push_back('{4'h1, 32'h80000000, 32'd1, 32'h0, 1'b0, 32'h7FFFFFFF, 4'b0011, 1, "sub_ovf"});

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].cin,
           vecs[i].res, vecs[i].flg, vecs[i].lat, vecs[i].nm, a0);
    end
    drain();

    // Back-to-back: next accept lands the cycle after the output handshake.
    send(4'h0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd3, 4'b0000, 1, "b2b_first", a0);
    send(4'h0, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 4'b0000, 1, "b2b_second", a1);
    chk("b2b_accept_gap", 32'(a1 - a0), 32'd2);
    drain();

    // Backpressure: output held stable while out_ready is low.
    out_ready = 1'b0;
    send(4'h0, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5, 4'b0000, 1, "bp_add", a0);
    w = 0;
    while (out_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'd5);
      chk("bp_flags", {28'd0, flags}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset mid-multiply aborts silently.
    send(4'hC, 32'd3, 32'd4, 32'd0, 1'b0, 32'd12, 4'b0000, 33, "mul_aborted", a0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_result", result, 32'd0);
    reset = 1'b1;
    aborted += sb_q.size();
    sb_q.delete();
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_output", {31'd0, seen}, 32'd0);
    send(4'h0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 4'b0000, 1, "add_after_abort", a0);
    drain();

    chk("result_count", 32'(results_seen), 32'(issued - aborted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
